axi4_burst_master: RTL and testbench

AXI4 master burst engine that sits directly upstream of the AXI4 memory-mapped slave and drives its five channels.
- Accepts one simple command at a time (read or write, addr, len, size).
- Streams write beats in from a producer and streams read beats out to a consumer.
- Reports one completion per command.
- Used by the stimulus/traffic layer and by SoC-side logic that needs burst access to the slave memory.

---
 rtl/axi4_pkg.sv | 27 ++
 rtl/axi4_burst_master.sv | 187 ++++++++++++++++++
 tb/tb_axi4_burst_master.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_pkg.sv
// Shared response codes, master state encoding and 4 KB boundary helper for axi4_burst_master.
package axi4_pkg;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] BOUNDARY_4K = 32'h0000_1000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_DONE
    } mst_state_e;

    // True when a burst starting at addr_lo would run past the end of its 4 KB page.
    function automatic logic crosses_4k(input logic [11:0] addr_lo,
                                        input logic [7:0]  len,
                                        input logic [2:0]  size);
        logic [31:0] span;
        span = (32'(len) + 32'd1) << size;
        return (32'(addr_lo) + span) > BOUNDARY_4K;
    endfunction

endpackage

// File: rtl/axi4_burst_master.sv
// Single-outstanding AXI4 burst master: one command in, one AXI burst out, one completion pulse.
// Build option AXI4_MASTER_BOUNDARY_CHECK_EN rejects bursts that would cross a 4 KB page.
module axi4_burst_master
    import axi4_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  done,
    output logic [1:0]            done_resp,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY
);

    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

    mst_state_e            state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [7:0]            beat_cnt_q;
    logic [2:0]            size_q;
    logic                  awvalid_q;
    logic                  arvalid_q;
    logic                  drain_q;
    logic                  rd_err_q;
    logic [1:0]            done_resp_q;

    logic in_w, in_r, last_beat, w_fire, r_fire, r_term, r_bad, bnd_reject;
    logic unused_rresp0;

`ifdef AXI4_MASTER_BOUNDARY_CHECK_EN
    assign bnd_reject = crosses_4k(cmd_addr[11:0], cmd_len, cmd_size);
`else
    assign bnd_reject = 1'b0;
`endif

    assign in_w      = (state_q == ST_W);
    assign in_r      = (state_q == ST_R);
    assign last_beat = (beat_cnt_q == len_q);
    // A rejected write still consumes its beats so the producer stays aligned with the next command.
    assign w_fire    = in_w && wr_valid && (drain_q || WREADY);
    assign r_fire    = in_r && RVALID && rd_ready;
    assign r_term    = RLAST || last_beat || RRESP[1];
    assign r_bad     = rd_err_q || RRESP[1] || (RLAST && !last_beat);
    assign unused_rresp0 = RRESP[0];

    assign cmd_ready = ARESETn && (state_q == ST_IDLE);
    assign wr_ready  = in_w && (drain_q || WREADY);
    assign WVALID    = in_w && !drain_q && wr_valid;
    assign WDATA     = wr_data;
    assign WLAST     = in_w && !drain_q && last_beat;
    assign BREADY    = (state_q == ST_B);
    assign RREADY    = in_r && rd_ready;
    assign rd_valid  = in_r && RVALID;
    assign rd_data   = RDATA;
    assign rd_last   = in_r && RVALID && r_term;
    assign done      = (state_q == ST_DONE);
    assign done_resp = done_resp_q;

    assign AWADDR  = addr_q;
    assign AWLEN   = len_q;
    assign AWSIZE  = size_q;
    assign AWVALID = awvalid_q;
    assign ARADDR  = addr_q;
    assign ARLEN   = len_q;
    assign ARSIZE  = size_q;
    assign ARVALID = arvalid_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            beat_cnt_q  <= '0;
            awvalid_q   <= 1'b0;
            arvalid_q   <= 1'b0;
            drain_q     <= 1'b0;
            rd_err_q    <= 1'b0;
            done_resp_q <= RESP_OKAY;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_q      <= cmd_addr;
                        len_q       <= cmd_len;
                        size_q      <= cmd_size;
                        beat_cnt_q  <= '0;
                        drain_q     <= 1'b0;
                        rd_err_q    <= 1'b0;
                        done_resp_q <= RESP_OKAY;
                        if (cmd_size > MAX_SIZE) begin
                            done_resp_q <= RESP_SLVERR;
                            state_q     <= ST_DONE;
                        end else if (bnd_reject) begin
                            drain_q <= cmd_write;
                            state_q <= cmd_write ? ST_W : ST_DONE;
                            if (!cmd_write) done_resp_q <= RESP_SLVERR;
                        end else if (cmd_write) begin
                            awvalid_q <= 1'b1;
                            state_q   <= ST_AW;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= ST_AR;
                        end
                    end
                end
                ST_AW: begin
                    if (AWREADY) begin
                        awvalid_q <= 1'b0;
                        state_q   <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_fire) begin
                        if (last_beat) begin
                            state_q <= drain_q ? ST_DONE : ST_B;
                            if (drain_q) done_resp_q <= RESP_SLVERR;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 8'd1;
                        end
                    end
                end
                ST_B: begin
                    if (BVALID) begin
                        done_resp_q <= BRESP;
                        state_q     <= ST_DONE;
                    end
                end
                ST_AR: begin
                    if (ARREADY) begin
                        arvalid_q <= 1'b0;
                        state_q   <= ST_R;
                    end
                end
                ST_R: begin
                    if (r_fire) begin
                        beat_cnt_q <= beat_cnt_q + 8'd1;
                        rd_err_q   <= rd_err_q | RRESP[1];
                        if (r_term) begin
                            done_resp_q <= r_bad ? RESP_SLVERR : RESP_OKAY;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_burst_master.sv
// Scoreboard bench for axi4_burst_master against a small behavioural AXI4 memory slave.
module tb_axi4_burst_master;
    import axi4_pkg::*;

`ifdef AXI4_MASTER_BOUNDARY_CHECK_EN
    localparam bit BND_EN = 1'b1;
`else
    localparam bit BND_EN = 1'b0;
`endif

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [2:0]  cmd_size = '0;
    logic        wr_valid = 1'b0, wr_ready;
    logic [31:0] wr_data = '0;
    logic        rd_valid, rd_ready = 1'b0, rd_last;
    logic [31:0] rd_data;
    logic        done;
    logic [1:0]  done_resp;
    logic [15:0] AWADDR, ARADDR;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic        AWVALID, AWREADY = 1'b0;
    logic [31:0] WDATA;
    logic        WLAST, WVALID, WREADY = 1'b0;
    logic [1:0]  BRESP = '0;
    logic        BVALID = 1'b0, BREADY;
    logic        ARVALID, ARREADY = 1'b0;
    logic [31:0] RDATA = '0;
    logic [1:0]  RRESP = '0;
    logic        RLAST = 1'b0, RVALID = 1'b0, RREADY;

    axi4_burst_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .done_resp(done_resp),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t       exp_w_q[$];
    beat_t       exp_rd_q[$];
    logic [1:0]  exp_done_q[$];
    logic [31:0] wr_src_q[$];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] slv_mem [0:1023];

    int checks = 0;
    int errors = 0;

    // Slave model state
    int          aw_delay = 0, awv_cnt = 0, aw_wait_seen = 0;
    bit          aw_seen = 1'b0;
    logic [15:0] aw_first = '0;
    logic [7:0]  aw_first_len = '0;
    logic [15:0] aw_addr_m = '0, ar_addr_m = '0;
    logic [7:0]  aw_len_m = '0, ar_len_m = '0;
    int          w_idx = 0, r_idx = 0, n_aw = 0, n_ar = 0, w_hs_cnt = 0;
    bit          b_bad = 1'b0, b_pending = 1'b0, ar_active = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives slave, producer and consumer inputs just after each rising edge.
    initial begin
        logic [31:0] r_addr;
        forever begin
            @(posedge ACLK);
            #1;
            AWREADY = (awv_cnt >= aw_delay);
            WREADY  = 1'b1;
            ARREADY = 1'b1;
            BVALID  = b_pending;
            BRESP   = b_bad ? RESP_SLVERR : RESP_OKAY;
            RVALID  = ar_active;
            r_addr  = 32'(ar_addr_m) + 32'(r_idx) * 4;
            if (r_addr >= 32'h1000) begin
                RDATA = 32'hDEAD_BEEF;
                RRESP = RESP_SLVERR;
                RLAST = 1'b0;
            end else begin
                RDATA = slv_mem[r_addr[11:2]];
                RRESP = RESP_OKAY;
                RLAST = (r_idx == int'(ar_len_m));
            end
            wr_valid = (wr_src_q.size() > 0);
            wr_data  = wr_valid ? wr_src_q[0] : 32'd0;
            rd_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Observes handshakes on the falling edge and checks them against the scoreboard.
    initial begin
        beat_t       eb;
        logic [31:0] wa;
        forever begin
            @(negedge ACLK);
            if (BVALID && BREADY) b_pending = 1'b0;
            if (AWVALID && AWREADY) begin
                if (aw_seen) check_eq("aw_addr_at_hs", AWADDR, aw_first);
                n_aw++;
                aw_wait_seen = awv_cnt;
                awv_cnt   = 0;
                aw_seen   = 1'b0;
                aw_addr_m = AWADDR;
                aw_len_m  = AWLEN;
                w_idx     = 0;
                b_bad     = 1'b0;
            end else if (AWVALID) begin
                if (!aw_seen) begin
                    aw_seen      = 1'b1;
                    aw_first     = AWADDR;
                    aw_first_len = AWLEN;
                end
                check_eq("aw_addr_stable", AWADDR, aw_first);
                check_eq("aw_len_stable", AWLEN, aw_first_len);
                check_eq("w_before_aw", WVALID, 0);
                awv_cnt++;
            end
            if (WVALID && WREADY) begin
                check_eq("w_pending", exp_w_q.size() > 0, 1);
                if (exp_w_q.size() > 0) begin
                    eb = exp_w_q.pop_front();
                    check_eq("wdata", WDATA, eb.data);
                    check_eq("wlast", WLAST, eb.last);
                end
                wa = 32'(aw_addr_m) + 32'(w_idx) * 4;
                if (wa >= 32'h1000) b_bad = 1'b1;
                else slv_mem[wa[11:2]] = WDATA;
                if (w_idx == int'(aw_len_m)) b_pending = 1'b1;
                w_idx++;
                w_hs_cnt++;
            end
            if (wr_valid && wr_ready && wr_src_q.size() > 0) void'(wr_src_q.pop_front());
            if (RVALID && RREADY) begin
                if (RLAST || RRESP[1]) ar_active = 1'b0;
                r_idx++;
            end
            if (ARVALID && ARREADY) begin
                n_ar++;
                ar_active = 1'b1;
                ar_addr_m = ARADDR;
                ar_len_m  = ARLEN;
                r_idx     = 0;
            end
            if (rd_valid && rd_ready) begin
                check_eq("rd_pending", exp_rd_q.size() > 0, 1);
                if (exp_rd_q.size() > 0) begin
                    eb = exp_rd_q.pop_front();
                    check_eq("rd_data", rd_data, eb.data);
                    check_eq("rd_last", rd_last, eb.last);
                end
            end
            if (done) begin
                check_eq("done_expected", exp_done_q.size() > 0, 1);
                if (exp_done_q.size() > 0) check_eq("done_resp", done_resp, exp_done_q.pop_front());
                $display("txn complete t=%0t resp=%b", $time, done_resp);
            end
        end
    end

    task automatic send_cmd(input bit wr, input logic [15:0] addr, input logic [7:0] len,
                            input logic [2:0] size);
        bit ok = 1'b0;
        @(posedge ACLK);
        #1;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_size  = size;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge ACLK);
            if (cmd_ready) ok = 1'b1;
        end
        @(posedge ACLK);
        #1;
        cmd_valid = 1'b0;
        check_eq("cmd_accepted", ok, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_done_q.size() != 0 && n < 300) begin
            @(negedge ACLK);
            #1;
            n++;
        end
        check_eq("done_timeout", exp_done_q.size(), 0);
        check_eq("w_leftover", exp_w_q.size(), 0);
        check_eq("rd_leftover", exp_rd_q.size(), 0);
        exp_done_q.delete();
        exp_w_q.delete();
        exp_rd_q.delete();
    endtask

    task automatic push_write(input logic [15:0] addr, input logic [7:0] len, input bit on_bus,
                              input logic [1:0] resp);
        beat_t       eb;
        logic [31:0] d;
        logic [15:0] a;
        for (int i = 0; i <= int'(len); i++) begin
            d = $urandom;
            wr_src_q.push_back(d);
            eb.data = d;
            eb.last = (i == int'(len));
            if (on_bus) exp_w_q.push_back(eb);
            a = addr + 16'(i * 4);
            if (resp == RESP_OKAY) ref_mem[a[11:2]] = d;
        end
    endtask

    task automatic run_read(input logic [15:0] addr, input logic [7:0] len);
        beat_t       eb;
        logic [15:0] a;
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + 16'(i * 4);
            eb.data = ref_mem[a[11:2]];
            eb.last = (i == int'(len));
            exp_rd_q.push_back(eb);
        end
        exp_done_q.push_back(RESP_OKAY);
        send_cmd(1'b0, addr, len, 3'd2);
        wait_done();
    endtask

    initial begin
        beat_t eb;
        int    n0;
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = '0;
            slv_mem[i] = '0;
        end

        // Reset values
        repeat (3) @(posedge ACLK);
        #1;
        check_eq("rst_ctrl", {AWVALID, ARVALID, WVALID, BREADY, RREADY, wr_ready, rd_valid,
                              rd_last, done}, 0);
        check_eq("rst_awaddr", {AWADDR, AWLEN, AWSIZE}, 0);
        check_eq("rst_araddr", {ARADDR, ARLEN, ARSIZE}, 0);
        check_eq("rst_done_resp", done_resp, 0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        check_eq("cmd_ready_after_rst", cmd_ready, 1);

        // Write then read back a 4-beat burst
        push_write(16'h0010, 8'd3, 1'b1, RESP_OKAY);
        exp_done_q.push_back(RESP_OKAY);
        send_cmd(1'b1, 16'h0010, 8'd3, 3'd2);
        wait_done();
        run_read(16'h0010, 8'd3);

        // AWREADY held low for 5 cycles
        aw_delay = 5;
        push_write(16'h0040, 8'd1, 1'b1, RESP_OKAY);
        exp_done_q.push_back(RESP_OKAY);
        send_cmd(1'b1, 16'h0040, 8'd1, 3'd2);
        wait_done();
        aw_delay = 0;
        check_eq("aw_wait_cycles", aw_wait_seen, 5);
        run_read(16'h0040, 8'd1);

        // Read beyond memory: single error beat without RLAST
        eb.data = 32'hDEAD_BEEF;
        eb.last = 1'b1;
        exp_rd_q.push_back(eb);
        exp_done_q.push_back(RESP_SLVERR);
        send_cmd(1'b0, 16'h1000, 8'd3, 3'd2);
        wait_done();

        // Write crossing the 4 KB page
        n0 = n_aw;
        push_write(16'h0FF8, 8'd3, !BND_EN, RESP_SLVERR);
        exp_done_q.push_back(RESP_SLVERR);
        send_cmd(1'b1, 16'h0FF8, 8'd3, 3'd2);
        wait_done();
        check_eq("bnd_aw_count", n_aw - n0, BND_EN ? 0 : 1);
        check_eq("bnd_drained", wr_src_q.size(), 0);

        // Oversized beat: rejected with no bus activity
        n0 = n_ar;
        exp_done_q.push_back(RESP_SLVERR);
        send_cmd(1'b0, 16'h0020, 8'd0, 3'd3);
        wait_done();
        check_eq("size_err_no_ar", n_ar - n0, 0);

        // Reset in the middle of a write burst
        w_hs_cnt = 0;
        push_write(16'h0080, 8'd3, 1'b1, RESP_SLVERR);
        send_cmd(1'b1, 16'h0080, 8'd3, 3'd2);
        for (int i = 0; i < 100 && w_hs_cnt < 2; i++) begin
            @(negedge ACLK);
            #1;
        end
        check_eq("midw_reached", w_hs_cnt, 2);
        @(posedge ACLK);
        #2;
        ARESETn = 1'b0;
        #1;
        check_eq("midw_rst_ctrl", {AWVALID, ARVALID, WVALID, BREADY, RREADY, wr_ready, rd_valid,
                                   done}, 0);
        check_eq("midw_rst_resp", done_resp, 0);
        wr_src_q.delete();
        exp_w_q.delete();
        b_pending = 1'b0;
        ar_active = 1'b0;
        awv_cnt   = 0;
        aw_seen   = 1'b0;
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        check_eq("midw_cmd_ready", cmd_ready, 1);
        run_read(16'h0010, 8'd3);

        repeat (5) @(negedge ACLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
